mc_scoreboard: RTL and testbench



---
 rtl/mc_scoreboard_pkg.sv | 19 +
 rtl/mc_scoreboard_sb_prio_enc.sv | 19 +
 rtl/mc_scoreboard.sv | 104 ++++++++++
 tb/tb_mc_scoreboard.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mc_scoreboard_pkg.sv
// Shared types and constants for the multi-cycle scoreboard and the hazard unit.
// Register address width tracks REG_SIZE so both ends of the regWrite/writeReg path agree.
package mc_scoreboard_pkg;

    localparam int REG_SIZE = 5;
    localparam int SB_DEPTH = 4;
    localparam int SB_LAT_W = 4;

    typedef struct packed {
        logic                valid;
        logic [REG_SIZE-1:0] rd;
        logic [SB_LAT_W-1:0] cnt;
    } sb_entry_t;

    localparam logic [1:0] FORWARD_NONE = 2'b00;
    localparam logic [1:0] FORWARD_WB   = 2'b01;
    localparam logic [1:0] FORWARD_MEM  = 2'b10;

endpackage

// File: rtl/mc_scoreboard_sb_prio_enc.sv
// Lowest-index priority encoder; o_idx is 0 when nothing is requested.
module sb_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/mc_scoreboard.sv
// Pending-write scoreboard for mul/div: tracks in-flight destinations, stalls decode, emits W-stage writes.
// Define SB_EARLY_RELEASE_EN to drop stallD for the entry being written back in its wb cycle.
module mc_scoreboard
    import mc_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_SIZE,
    parameter int DEPTH      = SB_DEPTH,
    parameter int LAT_W      = SB_LAT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [LAT_W-1:0]      issue_lat,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] raddr1D,
    input  logic [REG_ADDR_W-1:0] raddr2D,
    output logic                  stallD,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [LAT_W-1:0]      cnt;
    } entry_t;

    entry_t r_ent [DEPTH];

    logic [DEPTH-1:0] w_free, w_expired, w_waw, w_hit1, w_hit2, w_grant_oh, w_stall_mask;
    logic             w_free_found, w_grant_found, w_accept;
    logic [IDX_W-1:0] w_free_idx, w_grant_idx;
    logic [LAT_W-1:0] w_init_cnt;

    sb_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_free_sel (
        .i_req   (w_free),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    sb_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_wb_grant (
        .i_req   (w_expired),
        .o_found (w_grant_found),
        .o_idx   (w_grant_idx)
    );

    always_comb begin
        w_free     = '0;
        w_expired  = '0;
        w_waw      = '0;
        w_hit1     = '0;
        w_hit2     = '0;
        w_grant_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_free[i]     = !r_ent[i].valid;
            w_expired[i]  = r_ent[i].valid && (r_ent[i].cnt == '0);
            w_waw[i]      = r_ent[i].valid && (r_ent[i].rd == issue_rd);
            w_hit1[i]     = r_ent[i].valid && (r_ent[i].rd == raddr1D);
            w_hit2[i]     = r_ent[i].valid && (r_ent[i].rd == raddr2D);
            w_grant_oh[i] = w_grant_found && (w_grant_idx == IDX_W'(i));
        end
    end

`ifdef SB_EARLY_RELEASE_EN
    assign w_stall_mask = ~w_grant_oh;
`else
    assign w_stall_mask = '1;
`endif

    // A granted entry is still valid this cycle, so it never counts as free: no same-cycle reuse.
    assign issue_ready = w_free_found && !((issue_rd != '0) && (|w_waw));
    assign w_accept    = issue_valid && issue_ready && (issue_rd != '0);
    assign w_init_cnt  = (issue_lat == '0) ? '0 : issue_lat - 1'b1;

    assign stallD   = ((raddr1D != '0) && (|(w_hit1 & w_stall_mask))) ||
                      ((raddr2D != '0) && (|(w_hit2 & w_stall_mask)));
    assign busy     = |(~w_free);
    // Entries discarded by reset must not leak a writeback in the reset cycle.
    assign wb_valid = w_grant_found && !reset;
    assign wb_rd    = wb_valid ? r_ent[w_grant_idx].rd : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_grant_oh[i]) begin
                    r_ent[i] <= '0;
                end else if (w_accept && (w_free_idx == IDX_W'(i))) begin
                    r_ent[i].valid <= 1'b1;
                    r_ent[i].rd    <= issue_rd;
                    r_ent[i].cnt   <= w_init_cnt;
                end else if (r_ent[i].valid && (r_ent[i].cnt != '0)) begin
                    r_ent[i].cnt <= r_ent[i].cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_scoreboard.sv
// Randomised + directed bench for mc_scoreboard against a due-time reference model.
module tb_mc_scoreboard;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic [3:0] issue_lat;
    logic       issue_ready;
    logic [4:0] raddr1D, raddr2D;
    logic       stallD, wb_valid, busy;
    logic [4:0] wb_rd;

    always #5 clk = ~clk;

    mc_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .issue_ready (issue_ready),
        .raddr1D     (raddr1D),
        .raddr2D     (raddr2D),
        .stallD      (stallD),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .busy        (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: each slot holds its destination and the absolute cycle its writeback becomes due.
    bit m_v   [DEPTH];
    int m_rd  [DEPTH];
    int m_due [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit iv, input int rd, input int lat,
                        input int r1, input int r2, input bit rst);
        int  g, fr, L;
        bit  waw, exp_rdy, exp_stall, exp_busy;
        @(negedge clk);
        reset       = rst;
        issue_valid = iv;
        issue_rd    = 5'(rd);
        issue_lat   = 4'(lat);
        raddr1D     = 5'(r1);
        raddr2D     = 5'(r2);
        #1;
        g = -1; fr = -1; waw = 0; exp_stall = 0; exp_busy = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && cyc >= m_due[i] && g < 0) g = i;
            if (!m_v[i] && fr < 0) fr = i;
            if (m_v[i]) begin
                exp_busy = 1;
                if (rd != 0 && m_rd[i] == rd) waw = 1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            bit skip;
            skip = 0;
`ifdef SB_EARLY_RELEASE_EN
            skip = (i == g);
`endif
            if (m_v[i] && !skip && ((r1 != 0 && m_rd[i] == r1) || (r2 != 0 && m_rd[i] == r2)))
                exp_stall = 1;
        end
        exp_rdy = (fr >= 0) && !waw;
        if (rst) begin
            chk("wb_valid_rst", wb_valid, 0);
            chk("wb_rd_rst", wb_rd, 0);
        end else begin
            chk("issue_ready", issue_ready, exp_rdy);
            chk("stallD", stallD, exp_stall);
            chk("busy", busy, exp_busy);
            chk("wb_valid", wb_valid, (g >= 0));
            chk("wb_rd", wb_rd, (g >= 0) ? m_rd[g] : 0);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
        end else begin
            if (g >= 0) m_v[g] = 0;
            if (iv && exp_rdy && rd != 0) begin
                L = (lat == 0) ? 1 : lat;
                m_v[fr]   = 1;
                m_rd[fr]  = rd;
                m_due[fr] = cyc + L;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input int r1, input int r2);
        for (int k = 0; k < n; k++) step(0, 0, 0, r1, r2, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0; m_rd[i] = 0; m_due[i] = 0;
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(1, 0, 0);

        // single op, lat 3, decode reading its destination
        step(1, 5, 3, 5, 0, 0);
        idle(5, 5, 0);

        // fill all entries, fifth issue blocked until first writeback
        step(1, 1, 8, 0, 0, 0);
        step(1, 2, 8, 0, 0, 0);
        step(1, 3, 8, 0, 0, 0);
        step(1, 4, 8, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(1, 6, 8, 1, 4, 0);
        idle(12, 0, 0);

        // two ops expiring in the same cycle
        step(1, 7, 2, 0, 8, 0);
        step(1, 8, 1, 0, 8, 0);
        idle(4, 7, 8);

        // WAW block on rd 9
        step(1, 9, 3, 9, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 9, 2, 9, 0, 0);
        idle(5, 9, 9);

        // rd 0 is never tracked
        step(1, 0, 4, 0, 0, 0);
        idle(6, 0, 0);

        // reset with three ops in flight
        step(1, 10, 8, 0, 0, 0);
        step(1, 11, 6, 0, 0, 0);
        step(1, 12, 1, 0, 0, 0);
        step(0, 0, 0, 10, 11, 1);
        idle(10, 10, 12);

        // zero latency treated as one, then random traffic
        step(1, 13, 0, 13, 0, 0);
        idle(3, 13, 0);
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(1, 0) == 1, $urandom_range(9), $urandom_range(6),
                 $urandom_range(9), $urandom_range(9), $urandom_range(149) == 0);
        end
        idle(20, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
